// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Decode stage: IF/ID register, field decode, load-use stall, branch resolve.
// Optional return-address stack enabled by defining RAS_EN.
// Revision : 1.0
// ============================================================================
module id_stage #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] if_pc,
  input  logic [15:0] if_inst,
  input  logic [15:0] rs_data,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_rd,
  output logic [2:0]  rs_addr,
  output logic        stall,
  output logic        br,
  output logic [15:0] br_pc,
  output logic        id_valid,
  output logic [15:0] id_pc,
  output logic [15:0] id_inst,
  output logic [2:0]  id_rd,
  output logic [15:0] id_imm,
  output logic        id_is_load,
  output logic        id_we,
  output logic        halted
);

  localparam logic [4:0] c_OP_HALT  = 5'h01;
  localparam logic [4:0] c_OP_LOAD  = 5'h02;
  localparam logic [4:0] c_OP_STORE = 5'h03;
  localparam logic [4:0] c_OP_BZ    = 5'h10;
  localparam logic [4:0] c_OP_BNZ   = 5'h11;
  localparam logic [4:0] c_OP_JMP   = 5'h18;
  localparam logic [4:0] c_OP_CALL  = 5'h19;
  localparam logic [4:0] c_OP_RET   = 5'h1A;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_depth_check
    $error("RAS_DEPTH must be a power of 2 and at least 2");
  end

  logic        r_valid;
  logic [15:0] r_pc;
  logic [15:0] r_inst;
  logic        r_halted;

  logic [4:0]  w_op;
  logic [2:0]  w_rs;
  logic [2:0]  w_rt;
  logic        w_is_halt, w_is_load, w_is_store, w_is_alu;
  logic        w_is_bz, w_is_bnz, w_is_jmp, w_is_call, w_is_ret;
  logic        w_ret_reads_rs;
  logic        w_reads_rs, w_reads_rt;
  logic        w_hazard, w_stall, w_fire, w_taken, w_br;
  logic [15:0] w_pc_inc, w_sext8, w_sext11, w_ret_pc, w_br_pc;

  assign w_op = r_inst[15:11];
  assign w_rs = r_inst[7:5];
  assign w_rt = r_inst[4:2];

  assign w_is_halt  = (w_op == c_OP_HALT);
  assign w_is_load  = (w_op == c_OP_LOAD);
  assign w_is_store = (w_op == c_OP_STORE);
  assign w_is_alu   = (w_op >= 5'h04) && (w_op <= 5'h0F);
  assign w_is_bz    = (w_op == c_OP_BZ);
  assign w_is_bnz   = (w_op == c_OP_BNZ);
  assign w_is_jmp   = (w_op == c_OP_JMP);
  assign w_is_call  = (w_op == c_OP_CALL);
  assign w_is_ret   = (w_op == c_OP_RET);

  assign w_pc_inc = r_pc + 16'd1;
  assign w_sext8  = {{8{r_inst[7]}}, r_inst[7:0]};
  assign w_sext11 = {{5{r_inst[10]}}, r_inst[10:0]};

`ifdef RAS_EN
  // Pointer counts outstanding calls past the ring size, so a deep unwind keeps
  // reading the ring (oldest slots already overwritten) instead of going empty.
  localparam int c_IW = $clog2(RAS_DEPTH);
  localparam int c_PW = c_IW + 4;

  logic [15:0]     r_ras [RAS_DEPTH];
  logic [c_PW-1:0] r_ras_ptr;
  logic [c_PW-1:0] w_ras_top;

  assign w_ras_top      = r_ras_ptr - c_PW'(1);
  assign w_ret_pc       = (r_ras_ptr == '0) ? 16'h0000 : r_ras[w_ras_top[c_IW-1:0]];
  assign w_ret_reads_rs = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ras_ptr <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= 16'h0000;
    end else if (w_fire && w_is_call) begin
      r_ras[r_ras_ptr[c_IW-1:0]] <= w_pc_inc;
      r_ras_ptr                  <= r_ras_ptr + c_PW'(1);
    end else if (w_fire && w_is_ret && (r_ras_ptr != '0)) begin
      r_ras_ptr <= w_ras_top;
    end
  end
`else
  assign w_ret_pc       = rs_data;
  assign w_ret_reads_rs = 1'b1;
`endif

  assign w_reads_rs = w_is_alu | w_is_store | w_is_load | w_is_bz | w_is_bnz |
                      (w_is_ret & w_ret_reads_rs);
  assign w_reads_rt = w_is_alu | w_is_store;

  assign w_hazard = r_valid & ex_is_load &
                    ((w_reads_rs & (w_rs == ex_rd)) | (w_reads_rt & (w_rt == ex_rd)));
  assign w_stall  = r_halted | w_hazard;
  assign w_fire   = r_valid & ~w_stall;
  assign w_taken  = (w_is_bz & (rs_data == 16'h0000)) | (w_is_bnz & (rs_data != 16'h0000)) |
                    w_is_jmp | w_is_call | w_is_ret;
  assign w_br     = w_fire & w_taken;

  always_comb begin
    w_br_pc = w_pc_inc + w_sext8;
    if (w_is_jmp || w_is_call) w_br_pc = w_pc_inc + w_sext11;
    else if (w_is_ret)         w_br_pc = w_ret_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_pc     <= 16'h0000;
      r_inst   <= 16'h0000;
      r_halted <= 1'b0;
    end else begin
      if (w_fire && w_is_halt) r_halted <= 1'b1;
      if (!w_stall) begin
        // The fetch captured on a redirect edge is wrong-path: squash it.
        if (w_br || r_halted) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= 1'b1;
          r_pc    <= if_pc;
          r_inst  <= if_inst;
        end
      end
    end
  end

  assign rs_addr    = w_rs;
  assign stall      = w_stall;
  assign br         = w_br;
  assign br_pc      = w_br_pc;
  assign id_valid   = w_fire;
  assign id_pc      = r_pc;
  assign id_inst    = r_inst;
  assign id_rd      = w_is_call ? 3'd7 : r_inst[10:8];
  assign id_imm     = w_is_call ? w_pc_inc : w_sext8;
  assign id_is_load = w_is_load;
  assign id_we      = w_is_load | w_is_alu | w_is_call;
  assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// Testbench for id_stage: directed scenarios plus randomized run against a
// behavioural model of the decode stage (RAS behaviour follows RAS_EN).
module tb_id_stage;

`ifdef RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  localparam logic [15:0] NOP   = 16'h0000;
  localparam logic [15:0] HALTI = 16'h0800;
  localparam logic [15:0] LOADR3 = 16'h1300;  // LOAD r3, rs=r0
  localparam logic [15:0] ADDR3 = 16'h2160;   // ALU rd=r1, rs=r3, rt=r0
  localparam logic [15:0] JMP5  = 16'hC005;
  localparam logic [15:0] JMP1  = 16'hC001;
  localparam logic [15:0] BZFE  = 16'h80FE;
  localparam logic [15:0] CALL1F = 16'hC81F;
  localparam logic [15:0] CALL0F = 16'hC80F;
  localparam logic [15:0] RETI  = 16'hD000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_pc, if_inst, rs_data;
  logic        ex_is_load;
  logic [2:0]  ex_rd;
  logic [2:0]  rs_addr;
  logic        stall, br, id_valid, id_is_load, id_we, halted;
  logic [15:0] br_pc, id_pc, id_inst, id_imm;
  logic [2:0]  id_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .rs_data(rs_data),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .rs_addr(rs_addr), .stall(stall),
    .br(br), .br_pc(br_pc), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_rd(id_rd), .id_imm(id_imm), .id_is_load(id_is_load), .id_we(id_we),
    .halted(halted)
  );

  // Inputs change on the falling edge; outputs are observed 1 time unit later.
  task automatic cyc(input logic r, input logic [15:0] pc, input logic [15:0] inst,
                     input logic [15:0] rsd, input logic exl, input logic [2:0] exrd);
    @(negedge clk);
    rst = r; if_pc = pc; if_inst = inst; rs_data = rsd; ex_is_load = exl; ex_rd = exrd;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 16'h0, NOP, 16'h0, 1'b0, 3'd0);
    cyc(1'b1, 16'h0, NOP, 16'h0, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    do_reset();
    cyc(1'b0, 16'h0005, HALTI, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0006, JMP5, 16'h0, 1'b0, 3'd0);
    cyc(1'b1, 16'h0007, NOP, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0008, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %h want 0", id_valid); end
    n_checks++; if (id_pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", id_pc); end
    n_checks++; if (id_inst !== 16'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", id_inst); end
    n_checks++; if (br !== 1'b0) begin n_fail++; $display("FAIL reset_br: got %h want 0", br); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %h want 0", stall); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %h want 0", halted); end
  endtask

  task automatic test_straight();
    do_reset();
    cyc(1'b0, 16'h0000, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL straight_first: got %h want 0", id_valid); end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 16'(k + 1), NOP, 16'h0, 1'b0, 3'd0);
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 16'(k) || br !== 1'b0) begin
        n_fail++; $display("FAIL straight_pc%0d: got v=%h pc=%h br=%h want v=1 pc=%h br=0", k, id_valid, id_pc, br, 16'(k));
      end
    end
  endtask

  task automatic test_jmp();
    do_reset();
    cyc(1'b0, 16'h0004, JMP5, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0005, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++; if (br !== 1'b1 || br_pc !== 16'h000A) begin n_fail++; $display("FAIL jmp_target: got br=%h pc=%h want br=1 pc=000a", br, br_pc); end
    cyc(1'b0, 16'h000A, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_bubble: got %h want 0", id_valid); end
    cyc(1'b0, 16'h000B, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 16'h000A) begin n_fail++; $display("FAIL jmp_landed: got v=%h pc=%h want v=1 pc=000a", id_valid, id_pc); end
    do_reset();
    cyc(1'b0, 16'hFFFE, JMP1, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'hFFFF, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++; if (br !== 1'b1 || br_pc !== 16'h0000) begin n_fail++; $display("FAIL jmp_wrap: got br=%h pc=%h want br=1 pc=0000", br, br_pc); end
  endtask

  task automatic test_bz();
    do_reset();
    cyc(1'b0, 16'h0010, BZFE, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0011, NOP, 16'h0000, 1'b0, 3'd0);
    n_checks++; if (br !== 1'b1 || br_pc !== 16'h000F) begin n_fail++; $display("FAIL bz_taken: got br=%h pc=%h want br=1 pc=000f", br, br_pc); end
    do_reset();
    cyc(1'b0, 16'h0010, BZFE, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0011, NOP, 16'h0005, 1'b0, 3'd0);
    n_checks++; if (br !== 1'b0 || rs_addr !== 3'd7) begin n_fail++; $display("FAIL bz_not_taken: got br=%h rs=%h want br=0 rs=7", br, rs_addr); end
    cyc(1'b0, 16'h0012, NOP, 16'h0005, 1'b0, 3'd0);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0011) begin n_fail++; $display("FAIL bz_fallthru: got v=%h pc=%h want v=1 pc=0011", id_valid, id_pc); end
  endtask

  task automatic test_load_use();
    do_reset();
    cyc(1'b0, 16'h0000, LOADR3, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0001, ADDR3, 16'h0, 1'b0, 3'd0);
    n_checks++;
    if (id_is_load !== 1'b1 || id_we !== 1'b1 || id_rd !== 3'd3 || stall !== 1'b0) begin
      n_fail++; $display("FAIL load_decode: got ld=%h we=%h rd=%h st=%h want 1 1 3 0", id_is_load, id_we, id_rd, stall);
    end
    cyc(1'b0, 16'h0002, NOP, 16'h0, 1'b1, 3'd3);
    n_checks++; if (stall !== 1'b1 || id_valid !== 1'b0 || br !== 1'b0) begin n_fail++; $display("FAIL load_use_stall: got st=%h v=%h br=%h want 1 0 0", stall, id_valid, br); end
    cyc(1'b0, 16'h0002, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++;
    if (stall !== 1'b0 || id_valid !== 1'b1 || id_pc !== 16'h0001 || id_rd !== 3'd1) begin
      n_fail++; $display("FAIL load_use_replay: got st=%h v=%h pc=%h rd=%h want 0 1 0001 1", stall, id_valid, id_pc, id_rd);
    end
  endtask

  task automatic test_halt();
    do_reset();
    cyc(1'b0, 16'h0007, HALTI, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0008, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0007 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_in_id: got v=%h pc=%h h=%h want 1 0007 0", id_valid, id_pc, halted); end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 16'(9 + k), NOP, 16'h0, 1'b0, 3'd0);
      n_checks++;
      if (halted !== 1'b1 || stall !== 1'b1 || id_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_hold%0d: got h=%h st=%h v=%h want 1 1 0", k, halted, stall, id_valid);
      end
    end
    cyc(1'b1, 16'h0, NOP, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++; if (halted !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL halt_cleared: got h=%h st=%h want 0 0", halted, stall); end
  endtask

  task automatic test_call_ret();
    logic [15:0] exp_ret;
    exp_ret = RAS ? 16'h0021 : 16'h1234;
    do_reset();
    cyc(1'b0, 16'h0020, CALL1F, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0021, NOP, 16'h0, 1'b0, 3'd0);
    n_checks++;
    if (br !== 1'b1 || br_pc !== 16'h0040 || id_rd !== 3'd7 || id_imm !== 16'h0021 || id_we !== 1'b1) begin
      n_fail++; $display("FAIL call: got br=%h pc=%h rd=%h imm=%h we=%h want 1 0040 7 0021 1", br, br_pc, id_rd, id_imm, id_we);
    end
    cyc(1'b0, 16'h0040, RETI, 16'h0, 1'b0, 3'd0);
    cyc(1'b0, 16'h0041, NOP, 16'h1234, 1'b0, 3'd0);
    n_checks++; if (br !== 1'b1 || br_pc !== exp_ret) begin n_fail++; $display("FAIL ret: got br=%h pc=%h want br=1 pc=%h", br, br_pc, exp_ret); end
  endtask

  task automatic test_ras_overflow();
    logic [15:0] mem [4];
    logic [15:0] exp_pc, p;
    int depth;
    depth = 0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      p = 16'h0100 + 16'(16 * k);
      cyc(1'b0, p, CALL0F, 16'h0, 1'b0, 3'd0);
      cyc(1'b0, p + 16'd1, NOP, 16'h0, 1'b0, 3'd0);
      n_checks++; if (br !== 1'b1 || br_pc !== p + 16'd16) begin n_fail++; $display("FAIL nest_call%0d: got br=%h pc=%h want br=1 pc=%h", k, br, br_pc, p + 16'd16); end
      mem[depth % 4] = p + 16'd1;
      depth++;
    end
    for (int j = 0; j < 6; j++) begin
      if (depth == 0) exp_pc = 16'h0000;
      else begin exp_pc = mem[(depth - 1) % 4]; depth--; end
      cyc(1'b0, 16'h0200 + 16'(4 * j), RETI, 16'h0, 1'b0, 3'd0);
      cyc(1'b0, 16'h0201 + 16'(4 * j), NOP, 16'hBEEF, 1'b0, 3'd0);
      n_checks++; if (br !== 1'b1 || br_pc !== exp_pc) begin n_fail++; $display("FAIL nest_ret%0d: got br=%h pc=%h want br=1 pc=%h", j, br, br_pc, exp_pc); end
    end
  endtask

  task automatic test_random();
    logic        mv, mh, r, exl, rrs, rrt, est, evo, etk, ebr, ewe;
    logic [15:0] mpc, minst, pc, inst, rsd, etgt, eimm, pop;
    logic [15:0] mras [4];
    logic [4:0]  op;
    logic [2:0]  exrd, erd;
    int depth;
    do_reset();
    mv = 0; mh = 0; mpc = 0; minst = 0; depth = 0;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 11))
        0: op = 5'h00; 1: op = 5'h02; 2: op = 5'h03; 3: op = 5'h10; 4: op = 5'h11;
        5: op = 5'h18; 6: op = 5'h19; 7: op = 5'h1A; 8: op = 5'h1F;
        default: op = 5'(4 + $urandom_range(0, 11));
      endcase
      inst = {op, 11'($urandom)};
      pc   = 16'($urandom);
      rsd  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      exl  = 1'($urandom_range(0, 1));
      exrd = 3'($urandom);
      cyc(r, pc, inst, rsd, exl, exrd);

      op  = minst[15:11];
      rrt = (op >= 5'h04 && op <= 5'h0F) || op == 5'h03;
      rrs = rrt || op == 5'h02 || op == 5'h10 || op == 5'h11 || (op == 5'h1A && !RAS);
      est = mh || (mv && exl && ((rrs && minst[7:5] == exrd) || (rrt && minst[4:2] == exrd)));
      evo = mv && !est;
      pop = (depth == 0) ? 16'h0 : mras[(depth - 1) % 4];
      etk = (op == 5'h10 && rsd == 0) || (op == 5'h11 && rsd != 0) || op == 5'h18 || op == 5'h19 || op == 5'h1A;
      ebr = evo && etk;
      if (op == 5'h18 || op == 5'h19) etgt = mpc + 16'd1 + {{5{minst[10]}}, minst[10:0]};
      else if (op == 5'h1A)           etgt = RAS ? pop : rsd;
      else                            etgt = mpc + 16'd1 + {{8{minst[7]}}, minst[7:0]};
      erd  = (op == 5'h19) ? 3'd7 : minst[10:8];
      eimm = (op == 5'h19) ? mpc + 16'd1 : {{8{minst[7]}}, minst[7:0]};
      ewe  = op == 5'h02 || (op >= 5'h04 && op <= 5'h0F) || op == 5'h19;

      n_checks++;
      if (stall !== est || id_valid !== evo || br !== ebr || halted !== mh) begin
        n_fail++; $display("FAIL rand%0d_ctl: got st=%h v=%h br=%h h=%h want %h %h %h %h", n, stall, id_valid, br, halted, est, evo, ebr, mh);
      end
      n_checks++;
      if (id_pc !== mpc || id_inst !== minst || id_rd !== erd || id_imm !== eimm || id_we !== ewe ||
          id_is_load !== (op == 5'h02) || rs_addr !== minst[7:5]) begin
        n_fail++; $display("FAIL rand%0d_dec: got pc=%h inst=%h rd=%h imm=%h we=%h want %h %h %h %h %h", n, id_pc, id_inst, id_rd, id_imm, id_we, mpc, minst, erd, eimm, ewe);
      end
      if (ebr) begin
        n_checks++;
        if (br_pc !== etgt) begin n_fail++; $display("FAIL rand%0d_target: got %h want %h", n, br_pc, etgt); end
      end

      if (r) begin
        mv = 0; mh = 0; mpc = 0; minst = 0; depth = 0;
      end else begin
        if (RAS && evo && op == 5'h19) begin mras[depth % 4] = mpc + 16'd1; depth++; end
        else if (RAS && evo && op == 5'h1A && depth > 0) depth--;
        if (!est) begin
          if (ebr || mh) mv = 0;
          else begin mv = 1; mpc = pc; minst = inst; end
        end
        if (evo && op == 5'h01) mh = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; if_pc = 16'h0; if_inst = NOP; rs_data = 16'h0; ex_is_load = 1'b0; ex_rd = 3'd0;
    test_reset();
    test_straight();
    test_jmp();
    test_bz();
    test_load_use();
    test_halt();
    test_call_ret();
    if (RAS) test_ras_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
